// File: rtl/framebuffer_reader.sv
// -----------------------------------------------------------------------------
// framebuffer_reader
//
// Purpose: accepts a read command (byte offset from confAddr plus a pixel
// count), fetches that framebuffer region over an AXI4 read master using INCR
// bursts (one burst outstanding, bursts never cross a 4 KiB boundary), and
// unpacks each STREAM_WIDTH beat into PIXEL_WIDTH pixels, lowest pixel first,
// with tlast on the final pixel of the command.
//
// Ports:
//   aclk, reset            clock, asynchronous active-high reset
//   confAddr               framebuffer base byte address
//   s_cmd_*                command stream (taddr = byte offset, tcount = pixels)
//   m_pixel_*              pixel output stream
//   m_mem_axi_ar* / r*     AXI4 read address / read data channels
//   busy                   command in progress (acceptance .. last pixel)
//   error                  sticky non-OKAY rresp flag, cleared on next command
// -----------------------------------------------------------------------------
module framebuffer_reader #(
    parameter int STREAM_WIDTH  = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int PIXEL_WIDTH   = 16,
    parameter int COUNT_WIDTH   = 22,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   confAddr,
    input  logic                    s_cmd_tvalid,
    output logic                    s_cmd_tready,
    input  logic [ADDR_WIDTH-1:0]   s_cmd_taddr,
    input  logic [COUNT_WIDTH-1:0]  s_cmd_tcount,
    output logic                    m_pixel_tvalid,
    input  logic                    m_pixel_tready,
    output logic [PIXEL_WIDTH-1:0]  m_pixel_tdata,
    output logic                    m_pixel_tlast,
    output logic [ID_WIDTH-1:0]     m_mem_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_mem_axi_araddr,
    output logic [7:0]              m_mem_axi_arlen,
    output logic [2:0]              m_mem_axi_arsize,
    output logic [1:0]              m_mem_axi_arburst,
    output logic                    m_mem_axi_arlock,
    output logic [3:0]              m_mem_axi_arcache,
    output logic [2:0]              m_mem_axi_arprot,
    output logic                    m_mem_axi_arvalid,
    input  logic                    m_mem_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_mem_axi_rid,
    input  logic [STREAM_WIDTH-1:0] m_mem_axi_rdata,
    input  logic [1:0]              m_mem_axi_rresp,
    input  logic                    m_mem_axi_rlast,
    input  logic                    m_mem_axi_rvalid,
    output logic                    m_mem_axi_rready,
    output logic                    busy,
    output logic                    error
);
    localparam int PPB    = STREAM_WIDTH / PIXEL_WIDTH;
    localparam int BYTES  = STREAM_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int PSHIFT = $clog2(PPB);
    localparam int IDXW   = (PPB > 1) ? PSHIFT : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]   beats_left_q, beats_left_d;
    logic [COUNT_WIDTH-1:0]   pix_left_q, pix_left_d;
    logic [STREAM_WIDTH-1:0]  buf_q, buf_d;
    logic                     buf_valid_q, buf_valid_d;
    logic [IDXW-1:0]          pix_idx_q, pix_idx_d;
    logic                     error_q, error_d;

    // ceil(count / PPB), computed one bit wider so the rounding add cannot wrap
    logic [COUNT_WIDTH:0]     cnt_round;
    logic [COUNT_WIDTH-1:0]   beats_cmd;
    assign cnt_round = {1'b0, s_cmd_tcount} + (COUNT_WIDTH + 1)'(PPB - 1);
    assign beats_cmd = COUNT_WIDTH'(cnt_round >> PSHIFT);

    // Beats that fit before the next 4 KiB page; addr_q is always beat aligned
    logic [12:0] to4k_bytes, to4k_beats;
    logic [31:0] burst32;
    assign to4k_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    assign to4k_beats = to4k_bytes >> BSHIFT;

    always_comb begin
        burst32 = 32'(beats_left_q);
        if (32'(MAX_BURST_LEN) < burst32) burst32 = 32'(MAX_BURST_LEN);
        if ({19'd0, to4k_beats} < burst32) burst32 = {19'd0, to4k_beats};
    end

    // Unpacker: pixel lanes of the held beat, padded to a power-of-two table
    logic [PIXEL_WIDTH-1:0] pix_lane [0:(1 << IDXW)-1];
    genvar gi;
    generate
        for (gi = 0; gi < (1 << IDXW); gi++) begin : g_lane
            if (gi < PPB) begin : g_used
                assign pix_lane[gi] = buf_q[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
            end else begin : g_pad
                assign pix_lane[gi] = '0;
            end
        end
    endgenerate

    logic pix_fire, last_in_beat, r_fire;
    assign m_pixel_tvalid = buf_valid_q;
    assign m_pixel_tdata  = pix_lane[pix_idx_q];
    assign m_pixel_tlast  = buf_valid_q && (pix_left_q == COUNT_WIDTH'(1));
    assign pix_fire       = buf_valid_q && m_pixel_tready;
    assign last_in_beat   = (pix_idx_q == IDXW'(PPB - 1));
    // A new beat may land in the same cycle the last pixel of the old one leaves
    assign m_mem_axi_rready = (state_q == S_DATA) &&
                              (!buf_valid_q || (pix_fire && last_in_beat));
    assign r_fire = m_mem_axi_rvalid && m_mem_axi_rready;

    assign s_cmd_tready      = (state_q == S_IDLE);
    assign busy              = (state_q != S_IDLE);
    assign error             = error_q;
    assign m_mem_axi_arvalid = (state_q == S_ADDR);
    assign m_mem_axi_araddr  = addr_q;
    assign m_mem_axi_arlen   = (state_q == S_ADDR) ? (burst32[7:0] - 8'd1) : 8'd0;
    assign m_mem_axi_arsize  = 3'(BSHIFT);
    assign m_mem_axi_arburst = 2'b01;
    assign m_mem_axi_arid    = '0;
    assign m_mem_axi_arlock  = 1'b0;
    assign m_mem_axi_arcache = 4'd0;
    assign m_mem_axi_arprot  = 3'd0;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        pix_left_d   = pix_left_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        pix_idx_d    = pix_idx_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE: begin
                if (s_cmd_tvalid) begin
                    error_d      = 1'b0;
                    addr_d       = confAddr + (s_cmd_taddr & ALIGN_MASK);
                    beats_left_d = beats_cmd;
                    pix_left_d   = s_cmd_tcount;
                    if (s_cmd_tcount != '0) state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_mem_axi_arready) begin
                    addr_d       = addr_q + ADDR_WIDTH'(burst32 << BSHIFT);
                    beats_left_d = beats_left_q - COUNT_WIDTH'(burst32);
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (r_fire && m_mem_axi_rlast)
                    state_d = (beats_left_q != '0) ? S_ADDR : S_DRAIN;
            end
            S_DRAIN: begin
                if (pix_fire && m_pixel_tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pixel consumption; tlast drops any unused trailing pixels of the beat
        if (pix_fire) begin
            pix_left_d = pix_left_q - COUNT_WIDTH'(1);
            if (m_pixel_tlast || last_in_beat) buf_valid_d = 1'b0;
            else                               pix_idx_d   = pix_idx_q + IDXW'(1);
        end
        if (r_fire) begin
            buf_d       = m_mem_axi_rdata;
            buf_valid_d = 1'b1;
            pix_idx_d   = '0;
            if (m_mem_axi_rresp != 2'b00) error_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            pix_left_q   <= '0;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            pix_idx_q    <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            pix_left_q   <= pix_left_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            pix_idx_q    <= pix_idx_d;
            error_q      <= error_d;
        end
    end

    // rid carries no information for a single-outstanding master
    logic unused_sig;
    assign unused_sig = ^{m_mem_axi_rid, burst32[31:8]};

endmodule

// File: tb/tb_framebuffer_reader.sv
module tb_framebuffer_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] conf_addr = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [21:0] cmd_count = '0;
    logic        tvalid, tready, tlast;
    logic [15:0] tdata;
    logic [7:0]  arid, arlen, rid;
    logic [31:0] araddr, rdata;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, rresp;
    logic        arlock, arvalid, arready, rlast, rvalid, rready, busy, error;
    logic [3:0]  arcache;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    framebuffer_reader dut (
        .aclk(clk), .reset(rst), .confAddr(conf_addr),
        .s_cmd_tvalid(cmd_valid), .s_cmd_tready(cmd_ready),
        .s_cmd_taddr(cmd_addr), .s_cmd_tcount(cmd_count),
        .m_pixel_tvalid(tvalid), .m_pixel_tready(tready),
        .m_pixel_tdata(tdata), .m_pixel_tlast(tlast),
        .m_mem_axi_arid(arid), .m_mem_axi_araddr(araddr), .m_mem_axi_arlen(arlen),
        .m_mem_axi_arsize(arsize), .m_mem_axi_arburst(arburst), .m_mem_axi_arlock(arlock),
        .m_mem_axi_arcache(arcache), .m_mem_axi_arprot(arprot),
        .m_mem_axi_arvalid(arvalid), .m_mem_axi_arready(arready),
        .m_mem_axi_rid(rid), .m_mem_axi_rdata(rdata), .m_mem_axi_rresp(rresp),
        .m_mem_axi_rlast(rlast), .m_mem_axi_rvalid(rvalid), .m_mem_axi_rready(rready),
        .busy(busy), .error(error)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents: pixel at pixel address pa (byte address / 2)
    function automatic logic [15:0] pixf(input logic [31:0] pa);
        return pa[15:0] ^ 16'hC3A5;
    endfunction

    // Observation logs, filled by the bus model
    logic [31:0] ar_addr_log[$];
    int          ar_len_log[$];
    int          ar_rise_log[$];
    int          rlast_log[$];
    int          r_hs_log[$];
    logic [15:0] pix_log[$];
    logic        last_log[$];
    int          pix_cyc_log[$];
    int          busy_fall;
    int          cmd_cyc;

    bit          rnd_mode = 1'b0;
    int          err_beat = -1;
    int          g_beat = 0;

    // AXI slave + pixel sink: handshakes decided at the negedge, drives at posedge+1
    initial begin
        logic        ar_hs, r_hs, p_hs, arvalid_prev, busy_prev;
        logic [31:0] r_addr, pend_addr;
        int          r_left, pend_beats;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0; tready = 0;
        r_left = 0; r_addr = 0; pend_addr = 0; pend_beats = 0;
        arvalid_prev = 0; busy_prev = 0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            p_hs  = tvalid && tready;
            if (arvalid && !arvalid_prev) ar_rise_log.push_back(cyc);
            arvalid_prev = arvalid;
            if (busy_prev && !busy) busy_fall = cyc;
            busy_prev = busy;
            if (ar_hs) begin
                ar_addr_log.push_back(araddr);
                ar_len_log.push_back(int'(arlen));
                pend_addr  = araddr;
                pend_beats = int'(arlen) + 1;
            end
            if (r_hs) begin
                r_hs_log.push_back(cyc);
                if (rlast) rlast_log.push_back(cyc);
            end
            if (p_hs) begin
                pix_log.push_back(tdata);
                last_log.push_back(tlast);
                pix_cyc_log.push_back(cyc);
            end
            @(posedge clk); #1;
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0; tready = 0;
                r_left = 0; arvalid_prev = 0; busy_prev = 0;
                continue;
            end
            if (r_hs) begin
                rvalid = 0; rlast = 0;
                r_addr = r_addr + 32'd4;
                r_left--;
                g_beat++;
            end
            if (ar_hs) begin
                r_addr = pend_addr;
                r_left = pend_beats;
            end
            if (r_left > 0 && !rvalid && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                rvalid = 1;
                rdata  = {pixf((r_addr >> 1) + 32'd1), pixf(r_addr >> 1)};
                rresp  = (g_beat == err_beat) ? 2'd2 : 2'd0;
                rlast  = (r_left == 1);
            end
            arready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            tready  = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    typedef struct {
        logic [31:0] conf;
        logic [31:0] off;
        int          count;
        bit          rnd;
        int          err_beat;
        int          n_ar;
        logic [31:0] a0;
        int          l0;
        logic [31:0] a1;
        int          l1;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic apply(input int idx, input vec_t v);
        bit done;
        ar_addr_log.delete(); ar_len_log.delete(); ar_rise_log.delete();
        rlast_log.delete(); r_hs_log.delete(); pix_log.delete();
        last_log.delete(); pix_cyc_log.delete();
        busy_fall = -1;
        rnd_mode = v.rnd; err_beat = v.err_beat; g_beat = 0;
        @(posedge clk); #1;
        conf_addr = v.conf; cmd_addr = v.off; cmd_count = 22'(v.count); cmd_valid = 1;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1);
        cmd_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid = 0;
        done = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (pix_log.size() >= v.count && !busy) begin
                done = 1;
                break;
            end
        end
        check("done", done, 1);
        repeat (4) @(negedge clk);
        check("ar_count", ar_addr_log.size(), v.n_ar);
        if (v.n_ar >= 1 && ar_addr_log.size() >= 1) begin
            check("ar0_addr", ar_addr_log[0], v.a0);
            check("ar0_len", ar_len_log[0], v.l0);
            check("cmd_to_arvalid", ar_rise_log[0], cmd_cyc + 1);
        end
        if (v.n_ar >= 2 && ar_addr_log.size() >= 2) begin
            check("ar1_addr", ar_addr_log[1], v.a1);
            check("ar1_len", ar_len_log[1], v.l1);
            check("rlast_to_arvalid", ar_rise_log[1], rlast_log[0] + 1);
        end
        check("pix_count", pix_log.size(), v.count);
        for (int k = 0; k < v.count && k < pix_log.size(); k++) begin
            check("pix_data", pix_log[k], pixf((v.a0 >> 1) + 32'(k)));
            check("pix_last", last_log[k], (k == v.count - 1));
        end
        if (v.count > 0 && pix_cyc_log.size() > 0) begin
            check("busy_fall", busy_fall, pix_cyc_log[pix_cyc_log.size()-1] + 1);
            if (!v.rnd && r_hs_log.size() > 0)
                check("first_pix_lat", pix_cyc_log[0], r_hs_log[0] + 1);
        end
        check("error", error, v.err);
        check("busy_end", busy, 0);
        check("ready_end", cmd_ready, 1);
        $display("vec %0d: base=0x%08h count=%0d ars=%0d pixels=%0d error=%0b",
                 idx, v.a0, v.count, ar_addr_log.size(), pix_log.size(), error);
    endtask

    initial begin
        bit got;
        //          conf          off       cnt rnd eb  nar a0            l0  a1           l1 err
        vecs[0] = '{32'h1000,     32'h0,    8,  0, -1, 1, 32'h1000,     3,  32'h0,       0, 0};
        vecs[1] = '{32'h1000,     32'h0,    5,  0, -1, 1, 32'h1000,     2,  32'h0,       0, 0};
        vecs[2] = '{32'h1000,     32'h0,    40, 0, -1, 2, 32'h1000,     15, 32'h1040,    3, 0};
        vecs[3] = '{32'h0,        32'hFF8,  8,  0, -1, 2, 32'hFF8,      1,  32'h1000,    1, 0};
        vecs[4] = '{32'h2000,     32'h13,   7,  1, 1,  1, 32'h2010,     3,  32'h0,       0, 1};
        vecs[5] = '{32'h2000,     32'h0,    0,  0, -1, 0, 32'h2000,     0,  32'h0,       0, 0};
        vecs[6] = '{32'h0,        32'hFC0,  50, 1, -1, 2, 32'hFC0,      15, 32'h1000,    8, 0};
        vecs[7] = '{32'hFFFFFFF0, 32'h4,    6,  0, -1, 1, 32'hFFFFFFF4, 2,  32'h0,       0, 0};
        vecs[8] = '{32'h1000,     32'h4,    1,  0, -1, 1, 32'h1004,     0,  32'h0,       0, 0};
        vecs[9] = '{32'h3000,     32'h0,    33, 1, -1, 2, 32'h3000,     15, 32'h3040,    0, 0};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_arlen", arlen, 0);
        check("rst_araddr", araddr, 0);

        for (int i = 0; i < 10; i++) begin
            apply(i, vecs[i]);
            // the 40-pixel command: first burst of 32 pixels streams without bubbles
            if (i == 2 && pix_cyc_log.size() >= 32)
                check("no_bubble", pix_cyc_log[31] - pix_cyc_log[0], 31);
        end

        // Reset in the middle of a burst
        rnd_mode = 0; err_beat = -1;
        pix_log.delete();
        @(posedge clk); #1;
        conf_addr = 32'h1000; cmd_addr = 0; cmd_count = 22'd40; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (pix_log.size() >= 3) begin
                got = 1;
                break;
            end
        end
        check("mid_data_reached", got, 1);
        #1 rst = 1;
        #1;
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_rready", rready, 0);
        check("mid_rst_tvalid", tvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);
        apply(10, vecs[2]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Read-side counterpart of the framebuffer writer. Takes a read command (byte offset and pixel count), fetches the framebuffer region over an AXI4 read master in INCR bursts, and unpacks each STREAM_WIDTH beat into a PIXEL_WIDTH pixel stream with tlast on the final pixel. It feeds display scanout and framebuffer readback paths, and shares the pixel packing with the writer (pixel k of a beat occupies bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]).

## Interface
- STREAM_WIDTH, 32: AXI data width; PPB = STREAM_WIDTH/PIXEL_WIDTH pixels per beat (power of two, ≥1).
- ADDR_WIDTH, 32: AXI address width.
- ID_WIDTH, 8: AXI ID width.
- PIXEL_WIDTH, 16: pixel width in bits.
- COUNT_WIDTH, 22: width of the pixel count.
- MAX_BURST_LEN, 16: maximum beats per burst (1..256).
- aclk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- confAddr  in  ADDR_WIDTH  framebuffer base byte address.
- s_cmd_tvalid / s_cmd_tready  in/out  1  command handshake.
- s_cmd_taddr  in  ADDR_WIDTH  byte offset from confAddr; low log2(STREAM_WIDTH/8) bits are ignored (forced to 0).
- s_cmd_tcount  in  COUNT_WIDTH  number of pixels to read.
- m_pixel_tvalid / m_pixel_tready  out/in  1  pixel stream handshake.
- m_pixel_tdata  out  PIXEL_WIDTH  pixel.
- m_pixel_tlast  out  1  final pixel of the command.
- m_mem_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out  AXI widths  read address channel; arready  in.
- m_mem_axi_r{id,data,resp,last,valid}  in  AXI widths  read data channel; rready  out.
- busy  out  1  high from command acceptance until the last pixel handshake.
- error  out  1  sticky; set on any rresp≠0, cleared on the next command acceptance.

## Operation
- States: IDLE, ADDR, DATA, DRAIN.
- IDLE: s_cmd_tready=1. On handshake, latch beatsLeft=ceil(count/PPB), pixLeft=count, addr=confAddr+aligned offset, and clear error. count=0 → remain in IDLE with no AXI traffic and no pixels; otherwise go to ADDR.
- ADDR: burst beats = min(beatsLeft, MAX_BURST_LEN, beats remaining to the next 4 KiB boundary). Drive arlen=beats−1, araddr=addr, arsize=log2(STREAM_WIDTH/8), arburst=1, arid/arlock/arcache/arprot=0. On arready go to DATA, advance addr by beats*STREAM_WIDTH/8, and subtract beats from beatsLeft.
- DATA: only one burst is outstanding at a time. rready = !bufValid || (m_pixel_tvalid && m_pixel_tready && pixIdx==PPB−1). On an accepted beat, load the beat buffer and set pixIdx=0. On the rlast beat: beatsLeft>0 → ADDR; else → DRAIN.
- Unpacker: m_pixel_tdata = buffer[pixIdx*PIXEL_WIDTH +: PIXEL_WIDTH]; tvalid=bufValid. Each handshake increments pixIdx and decrements pixLeft. tlast is asserted when pixLeft==1. On the tlast handshake, unused trailing pixels of the final beat are discarded and bufValid clears.
- DRAIN: wait for the tlast handshake, then go to IDLE.
- rresp≠0: set error; the data is still emitted and the pixel count is unaffected.
- Address arithmetic is modulo 2^ADDR_WIDTH. rid is ignored.

## Timing
- Reset values: s_cmd_tready=1, arvalid=0, rready=0, m_pixel_tvalid=0, tlast=0, busy=0, error=0, state=IDLE, arlen=0, araddr=0.
- Command handshake at cycle T → arvalid=1 at T+1.
- arvalid and all ar* fields hold stable until arready. tvalid, tdata and tlast hold stable while tready=0.
- First pixel: tvalid is asserted the cycle after the first r handshake.
- With continuous rvalid and tready, throughput is one pixel per cycle with no bubble at beat boundaries.
- Between bursts, the next arvalid rises the cycle after the rlast handshake.
- busy falls, and s_cmd_tready rises, the cycle after the tlast handshake.
- Reset mid-operation: all state returns to reset values immediately. Any outstanding AXI transaction is abandoned; the interconnect is reset together with this block.

## Test plan
- confAddr=0x1000, offset=0, count=8 (STREAM 32 / PIXEL 16) → one AR with araddr=0x1000, arlen=3; pixels emitted low-half-first in order; tlast only on the 8th pixel.
- count=5 → arlen=2; the upper pixel of beat 3 is dropped; tlast on the 5th pixel; back to IDLE.
- count=40, MAX_BURST_LEN=16 → ARs at 0x1000 with arlen=15, then 0x1040 with arlen=3; 40 pixels; the second arvalid rises the cycle after the first rlast.
- confAddr=0, offset=0xFF8, count=8 → AR at 0xFF8 with arlen=1, then AR at 0x1000 with arlen=1 (no 4 KiB crossing).
- Random tready and rvalid gaps, plus rresp=2 on beat 2 → pixel sequence intact with no drops or duplicates; error=1 until the next command; a count=0 command produces no AR and clears error.
- Assert reset during DATA → arvalid, rready and tvalid are 0 immediately; a fresh command afterwards completes correctly.
